// File: rtl/text_overlay_pipe.sv
// 8x8-font text overlay stage: looks up a character code, then the glyph row, and keys
// set glyph pixels over the background with fixed latency LAT = 2*ROM_LAT + 2.
module text_overlay_pipe #(
  parameter int          H_RES      = 1280,
  parameter int          V_RES      = 720,
  parameter int          TEXT_X0    = 64,
  parameter int          TEXT_Y0    = 640,
  parameter int          COLS       = 80,
  parameter int          ROWS       = 1,
  parameter int          SCALE_LOG2 = 1,
  parameter int          ROM_LAT    = 1,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  localparam int         X_W        = $clog2(H_RES),
  localparam int         Y_W        = $clog2(V_RES),
  localparam int         TA_W       = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic            pixel_clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            in_active,
  input  logic            in_hsync,
  input  logic            in_vsync,
  input  logic [X_W-1:0]  x_coord,
  input  logic [Y_W-1:0]  y_coord,
  input  logic [7:0]      in_r,
  input  logic [7:0]      in_g,
  input  logic [7:0]      in_b,
  output logic [TA_W-1:0] text_addr,
  input  logic [7:0]      text_data,
  output logic [9:0]      font_addr,
  input  logic [7:0]      font_data,
  output logic            out_active,
  output logic            out_hsync,
  output logic            out_vsync,
  output logic [7:0]      out_r,
  output logic [7:0]      out_g,
  output logic [7:0]      out_b
);

  localparam int BOX_W  = (COLS * 8) << SCALE_LOG2;
  localparam int BOX_H  = (ROWS * 8) << SCALE_LOG2;
  localparam int X_END  = TEXT_X0 + BOX_W;
  localparam int Y_END  = TEXT_Y0 + BOX_H;
  // ROM_LAT counts the register here that captures each ROM's output, so a
  // ROM_LAT=1 ROM reads combinationally and the side band needs 2*ROM_LAT+1 slots.
  localparam int PIPE_D = 2 * ROM_LAT + 1;

  typedef struct packed {
    logic        inbox;
    logic [2:0]  gcol;
    logic [2:0]  grow;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;
  } stage_t;

  logic [X_W-1:0]  rx;
  logic [Y_W-1:0]  ry;
  logic [X_W-1:0]  col;
  logic [Y_W-1:0]  trow;
  logic            inbox;
  logic [TA_W-1:0] text_addr_next;
  stage_t          s0;
  stage_t          pipe [PIPE_D];
  stage_t          last;
  logic            pix_bit;
  logic            text_bit7_unused;

  assign text_bit7_unused = text_data[7];

  // Offsets wrap for pixels left of / above the box, but inbox masks them off.
  assign rx    = x_coord - X_W'(TEXT_X0);
  assign ry    = y_coord - Y_W'(TEXT_Y0);
  assign col   = rx >> (3 + SCALE_LOG2);
  assign trow  = ry >> (3 + SCALE_LOG2);
  assign inbox = in_active && enable
              && (int'(x_coord) >= TEXT_X0) && (int'(x_coord) < X_END)
              && (int'(y_coord) >= TEXT_Y0) && (int'(y_coord) < Y_END);

  assign text_addr_next = inbox ? TA_W'(int'(trow) * COLS + int'(col)) : '0;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    s0        = '0;
    s0.inbox  = inbox;
    s0.gcol   = rx[SCALE_LOG2 +: 3];
    s0.grow   = ry[SCALE_LOG2 +: 3];
    s0.active = in_active;
    s0.hsync  = in_hsync;
    s0.vsync  = in_vsync;
    s0.rgb    = {in_r, in_g, in_b};
  end

  assign last = pipe[PIPE_D-1];

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      // NOTE: the side-band array is real pipeline state, so it is flushed by reset
      // to keep stale pixels from emerging after a mid-frame reset.
      for (int i = 0; i < PIPE_D; i++) pipe[i] <= '0;
      text_addr  <= '0;
      font_addr  <= '0;
      pix_bit    <= 1'b0;
      out_active <= 1'b0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
    end else begin
      pipe[0]   <= s0;
      for (int i = 1; i < PIPE_D; i++) pipe[i] <= pipe[i-1];
      text_addr <= text_addr_next;
      font_addr <= {text_data[6:0], pipe[ROM_LAT-1].grow};
      pix_bit   <= font_data[3'd7 - pipe[2*ROM_LAT-1].gcol];

      out_active <= last.active;
      out_hsync  <= last.hsync;
      out_vsync  <= last.vsync;
      if (!last.active) begin
        {out_r, out_g, out_b} <= 24'h000000;
      end else if (last.inbox && pix_bit) begin
        {out_r, out_g, out_b} <= FG_RGB;
      end else begin
        {out_r, out_g, out_b} <= last.rgb;
      end
    end
  end

endmodule
